// File: rtl/csr_counter_bank.sv
// Zicntr/Zihpm counter bank: mcycle, minstret, mhpmcounters and their enables/inhibits.
// Optional overflow tracking (scountovf, lcofi_irq) is built when CSR_CNT_OVF_IRQ_EN is defined.
module csr_counter_bank #(
  parameter int XLEN     = 32,
  parameter int NUM_HPM  = 4,
  parameter int RETIRE_W = 1
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [$clog2(RETIRE_W+1)-1:0]             retire_cnt,
  input  logic [((NUM_HPM > 0) ? NUM_HPM : 1)-1:0]  hpm_event,
  input  logic [63:0]                               mtime,
  input  logic [1:0]                                priv,
  input  logic                                      req_valid,
  input  logic [11:0]                               req_addr,
  input  logic                                      req_wen,
  input  logic [XLEN-1:0]                           req_wdata,
  output logic                                      resp_valid,
  output logic [XLEN-1:0]                           resp_rdata,
  output logic                                      resp_illegal,
  output logic                                      resp_hit
`ifdef CSR_CNT_OVF_IRQ_EN
  ,
  output logic                                      lcofi_irq
`endif
);

  localparam int          HPM_N    = (NUM_HPM > 0) ? NUM_HPM : 1;
  localparam bit          IS32     = (XLEN == 32);
  localparam logic [1:0]  PRIV_U   = 2'd0;
  localparam logic [1:0]  PRIV_M   = 2'd3;
  localparam logic [31:0] HPM_MASK = 32'((64'd1 << (3 + NUM_HPM)) - 64'd8);
  localparam logic [31:0] EN_MASK  = HPM_MASK | 32'h0000_0007;
  localparam logic [31:0] INH_MASK = HPM_MASK | 32'h0000_0005;

  // XLEN32 writes replace only the addressed half; XLEN64 replaces the whole counter.
  function automatic logic [63:0] merge_write(input logic [63:0] cur, input logic [63:0] wd,
                                              input logic hi_half);
    logic [63:0] res;
    if (!IS32) begin
      res = wd;
    end else if (hi_half) begin
      res = {wd[31:0], cur[31:0]};
    end else begin
      res = {cur[63:32], wd[31:0]};
    end
    return res;
  endfunction

  function automatic logic [63:0] read_half(input logic [63:0] val, input logic hi_half);
    logic [63:0] res;
    if (IS32 && hi_half) begin
      res = {32'd0, val[63:32]};
    end else begin
      res = val;
    end
    return res;
  endfunction

  logic [63:0] mcycle_r;
  logic [63:0] minstret_r;
  logic [63:0] hpm_r [HPM_N];
  logic [31:0] inhibit_r;
  logic [31:0] mcen_r;
  logic [31:0] scen_r;
`ifdef CSR_CNT_OVF_IRQ_EN
  logic [HPM_N-1:0] of_r;
  logic [31:0]      ovf_val_s;
`endif

  logic [63:0]      wdata64_s;
  logic [3:0]       page_s;
  logic             hi_s;
  logic [4:0]       idx_s;
  logic             cnt_space_s;
  logic             is_mcnt_s;
  logic             is_ucnt_s;
  logic             is_inh_s;
  logic             is_mcen_s;
  logic             is_scen_s;
  logic             is_ovf_s;
  logic             hit_s;
  logic             not_m_s;
  logic             is_u_s;
  logic             ill_s;
  logic             wr_s;
  logic             wr_cnt_s;
  logic             wr_cyc_s;
  logic             wr_ret_s;
  logic [HPM_N-1:0] wr_hpm_s;
  logic [63:0]      hpm_sel_s;
  logic [63:0]      cnt_val_s;
  logic [63:0]      rd64_s;

  assign wdata64_s   = 64'(req_wdata);
  assign page_s      = req_addr[11:8];
  assign hi_s        = req_addr[7];
  assign idx_s       = req_addr[4:0];
  assign cnt_space_s = (req_addr[6:5] == 2'b00);

  // 0xB01/0xB81 have no M-mode counterpart; time exists only as the user alias.
  assign is_mcnt_s = (page_s == 4'hB) && cnt_space_s && (idx_s != 5'd1);
  assign is_ucnt_s = (page_s == 4'hC) && cnt_space_s;
  assign is_inh_s  = (req_addr == 12'h320);
  assign is_mcen_s = (req_addr == 12'h306);
  assign is_scen_s = (req_addr == 12'h106);
`ifdef CSR_CNT_OVF_IRQ_EN
  assign is_ovf_s  = (req_addr == 12'hDA0);
`else
  assign is_ovf_s  = 1'b0;
`endif
  assign hit_s = is_mcnt_s || is_ucnt_s || is_inh_s || is_mcen_s || is_scen_s || is_ovf_s;

  assign not_m_s = (priv != PRIV_M);
  assign is_u_s  = (priv == PRIV_U);

  assign ill_s = (is_ucnt_s && req_wen)
              || ((is_mcnt_s || is_inh_s || is_mcen_s) && not_m_s)
              || (is_scen_s && is_u_s)
              || (is_ucnt_s && not_m_s && !mcen_r[idx_s])
              || (is_ucnt_s && is_u_s && !scen_r[idx_s])
              || (!IS32 && hi_s && (is_mcnt_s || is_ucnt_s))
              || (is_ovf_s && (is_u_s || req_wen));

  assign wr_s     = req_valid && req_wen && hit_s && !ill_s;
  assign wr_cnt_s = wr_s && is_mcnt_s;
  assign wr_cyc_s = wr_cnt_s && (idx_s == 5'd0);
  assign wr_ret_s = wr_cnt_s && (idx_s == 5'd2);

  for (genvar gi = 0; gi < HPM_N; gi++) begin : g_wr_hpm
    assign wr_hpm_s[gi] = wr_cnt_s && (idx_s == 5'(3 + gi));
  end

  // One-hot gather of the addressed hpm counter; unimplemented indices fall out as zero.
  always_comb begin
    hpm_sel_s = 64'd0;
    for (int i = 0; i < NUM_HPM; i++) begin
      hpm_sel_s = hpm_sel_s | ({64{idx_s == 5'(3 + i)}} & hpm_r[i]);
    end
  end

  // Counter value addressed by the low five address bits.
  always_comb begin
    cnt_val_s = 64'd0;
    case (idx_s)
      5'd0:    cnt_val_s = mcycle_r;
      5'd1:    cnt_val_s = mtime;
      5'd2:    cnt_val_s = minstret_r;
      default: cnt_val_s = hpm_sel_s;
    endcase
  end

`ifdef CSR_CNT_OVF_IRQ_EN
  // Below M-mode only overflow bits of counters delegated via mcounteren are visible.
  assign ovf_val_s = ((32'(of_r) << 3) & HPM_MASK) & (not_m_s ? mcen_r : 32'hFFFF_FFFF);
`endif

  // Read multiplexer over all CSRs owned by the bank.
  always_comb begin
    rd64_s = 64'd0;
    case (1'b1)
      is_mcnt_s, is_ucnt_s: rd64_s = read_half(cnt_val_s, hi_s);
      is_inh_s:             rd64_s = {32'd0, inhibit_r};
      is_mcen_s:            rd64_s = {32'd0, mcen_r};
      is_scen_s:            rd64_s = {32'd0, scen_r};
`ifdef CSR_CNT_OVF_IRQ_EN
      is_ovf_s:             rd64_s = {32'd0, ovf_val_s};
`endif
      default:              rd64_s = 64'd0;
    endcase
  end

  // mcycle and minstret: a CSR write replaces the increment of that cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcycle_r   <= 64'd0;
      minstret_r <= 64'd0;
    end else begin
      if (wr_cyc_s) begin
        mcycle_r <= merge_write(mcycle_r, wdata64_s, hi_s);
      end else if (!inhibit_r[0]) begin
        mcycle_r <= mcycle_r + 64'd1;
      end else begin
        mcycle_r <= mcycle_r;
      end
      if (wr_ret_s) begin
        minstret_r <= merge_write(minstret_r, wdata64_s, hi_s);
      end else if (!inhibit_r[2]) begin
        minstret_r <= minstret_r + 64'(retire_cnt);
      end else begin
        minstret_r <= minstret_r;
      end
    end
  end

  if (NUM_HPM > 0) begin : g_hpm
    // Programmable counters advance on their event pulse unless inhibited or written.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < NUM_HPM; i++) begin
          hpm_r[i] <= 64'd0;
        end
      end else begin
        for (int i = 0; i < NUM_HPM; i++) begin
          if (wr_hpm_s[i]) begin
            hpm_r[i] <= merge_write(hpm_r[i], wdata64_s, hi_s);
          end else if (!inhibit_r[3+i] && hpm_event[i]) begin
            hpm_r[i] <= hpm_r[i] + 64'd1;
          end else begin
            hpm_r[i] <= hpm_r[i];
          end
        end
      end
    end

`ifdef CSR_CNT_OVF_IRQ_EN
    // Sticky overflow: set on an increment that wraps to zero, cleared by a counter write.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        of_r <= '0;
      end else begin
        for (int i = 0; i < NUM_HPM; i++) begin
          if (wr_hpm_s[i]) begin
            of_r[i] <= 1'b0;
          end else if (!inhibit_r[3+i] && hpm_event[i] && (hpm_r[i] == 64'hFFFF_FFFF_FFFF_FFFF)) begin
            of_r[i] <= 1'b1;
          end else begin
            of_r[i] <= of_r[i];
          end
        end
      end
    end
`endif
  end else begin : g_no_hpm
    assign hpm_r[0] = 64'd0;
`ifdef CSR_CNT_OVF_IRQ_EN
    assign of_r     = 1'b0;
`endif
  end

  // Enable/inhibit registers keep only their implemented bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inhibit_r <= 32'd0;
      mcen_r    <= 32'd0;
      scen_r    <= 32'd0;
    end else begin
      if (wr_s && is_inh_s) begin
        inhibit_r <= wdata64_s[31:0] & INH_MASK;
      end else begin
        inhibit_r <= inhibit_r;
      end
      if (wr_s && is_mcen_s) begin
        mcen_r <= wdata64_s[31:0] & EN_MASK;
      end else begin
        mcen_r <= mcen_r;
      end
      if (wr_s && is_scen_s) begin
        scen_r <= wdata64_s[31:0] & EN_MASK;
      end else begin
        scen_r <= scen_r;
      end
    end
  end

  // Single-stage response pipeline; data is the pre-update value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_valid   <= 1'b0;
      resp_hit     <= 1'b0;
      resp_illegal <= 1'b0;
      resp_rdata   <= '0;
    end else begin
      resp_valid   <= req_valid;
      resp_hit     <= req_valid && hit_s;
      resp_illegal <= req_valid && ill_s;
      if (req_valid && !ill_s) begin
        resp_rdata <= rd64_s[XLEN-1:0];
      end else begin
        resp_rdata <= '0;
      end
    end
  end

`ifdef CSR_CNT_OVF_IRQ_EN
  // Local counter-overflow interrupt request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lcofi_irq <= 1'b0;
    end else begin
      lcofi_irq <= |of_r;
    end
  end
`endif

endmodule

// File: doc/csr_counter_bank.md
Name: csr_counter_bank

Overview:
Parametrised Zicntr/Zihpm counter bank for the CSR unit. It holds mcycle, minstret, NUM_HPM programmable mhpmcounters, mcountinhibit, mcounteren and scounteren. It serves CSR read/write requests from the CSR stage for M-mode addresses and for their user aliases (0xC00+), with privilege checks. It supports XLEN 32 (split high/low halves) and XLEN 64.

Parameters:
XLEN, 32, data width of the CSR port: 32 or 64.
NUM_HPM, 4, number of hpmcounters, 0..29, mapped to indices 3..3+NUM_HPM-1.
RETIRE_W, 1, maximum instructions retired per cycle, 1..4.

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
retire_cnt  in  $clog2(RETIRE_W+1)  instructions retired this cycle
hpm_event  in  NUM_HPM  one-cycle event pulses; bit i drives counter 3+i
mtime  in  64  platform timer value, returned for time/timeh
priv  in  2  current privilege: 0=U, 1=S, 3=M
req_valid  in  1  CSR access request
req_addr  in  12  CSR address
req_wen  in  1  write request (CSRRW/S/C already resolved upstream)
req_wdata  in  XLEN  final write value
resp_valid  out  1  response strobe
resp_rdata  out  XLEN  old value of the addressed CSR
resp_illegal  out  1  access must raise ILLEGAL_INSTRUCTION
resp_hit  out  1  address belongs to this bank

Behaviour:
- Counters are 64 bits wide regardless of XLEN.
- Reset values: all counters, mcountinhibit, mcounteren, scounteren = 0; resp_valid/resp_rdata/resp_illegal/resp_hit = 0.
- Per-cycle increments, each suppressed when its mcountinhibit bit is set:
  - mcycle (IR bit 0): +1.
  - minstret (IR bit 2): +retire_cnt.
  - hpm i (IR bit 3+i): +1 when hpm_event[i] is high.
- Wrap: 64'hFFFF_FFFF_FFFF_FFFF + n wraps modulo 2^64.
- Handshake and latency:
  - req_valid is sampled at cycle N; resp_* is registered and valid at N+1 for exactly one cycle.
  - Back-to-back requests are allowed, one per cycle.
  - resp_rdata is the value before any same-cycle write or increment.
- Address map (XLEN32 adds high halves at addr+0x80):
  - M-mode counters: 0xB00 mcycle, 0xB02 minstret, 0xB03+i mhpmcounter.
  - User aliases: 0xC00 cycle, 0xC01 time, 0xC02 instret, 0xC03+i hpmcounter.
  - Control: 0x320 mcountinhibit, 0x306 mcounteren, 0x106 scounteren.
  - Unimplemented hpm indices read 0, ignore writes, and assert resp_hit.
- Masks: implemented bits in mcountinhibit, mcounteren and scounteren are bits 0–2 and 3..3+NUM_HPM-1. mcountinhibit bit 1 is read-only 0. Other bits are WARL 0.
- Illegal (resp_illegal=1, no write performed) when any of:
  - write to a 0xCxx alias;
  - access to 0xBxx or 0x3xx with priv≠M;
  - scounteren access with priv=U;
  - alias access with priv<M and mcounteren bit clear;
  - alias access with priv=U and scounteren bit clear;
  - XLEN64 access to a +0x80 high-half address.
- Writes: a write to a counter replaces the counter (or the addressed half for XLEN32). That cycle's increment is dropped. A low-half write with XLEN32 leaves the high half unchanged, with no carry.
- Reset asserted mid-request: resp_valid is 0 in the cycle after reset is released. The pending request is discarded.
- No internal FSM other than the 1-stage response pipeline. When NUM_HPM=0, no hpm storage is generated.

Optional Feature:
Macro CSR_CNT_OVF_IRQ_EN.
- Enabled:
  - Each hpm counter gets a sticky OF bit, set when an increment wraps it to 0.
  - OF bits are readable at 0xDA0 (scountovf, bit 3+i). Read access follows mcounteren gating; priv=U is always illegal.
  - OF bits are cleared by any write to the corresponding mhpmcounter.
  - Extra output lcofi_irq (1 bit, reset 0) = OR of all OF bits, registered. The core raises interrupt cause INTERRUPT_BIT|13.
- Disabled: no OF storage; 0xDA0 resp_hit=0; no lcofi_irq port.

Test Plan:
1. Reset, idle 10 cycles, read 0xB00 in M -> resp_rdata=10 (±pipeline constant fixed by bench) one cycle after request; resp_illegal=0.
2. XLEN32: write 0xB80=0x1, then write 0xB00=0xFFFF_FFFF; after 1 idle cycle read 0xB00 -> 0x0 and 0xB80 -> 0x2 (carry propagated).
3. priv=U, mcounteren=0x1, scounteren=0x0, read 0xC00 -> resp_illegal=1. Set scounteren=0x1, repeat -> legal. Write 0xC00 in M -> resp_illegal=1 and counter unchanged.
4. mcountinhibit=0x5, pulse retire_cnt=1 for 5 cycles -> mcycle and minstret frozen. Clear inhibit, retire_cnt=RETIRE_W=2 for 3 cycles -> minstret+6.
5. Write 0xB03=0x1234 in the same cycle hpm_event[0]=1 -> readback 0x1234. Preload 0xFFFF_FFFF_FFFF_FFFF, pulse event -> 0. With CSR_CNT_OVF_IRQ_EN, lcofi_irq=1 and 0xDA0 bit3=1.
6. Assert reset while req_valid=1 -> all outputs 0 during reset, no response after release, all counters read 0.
